uart_cmd_ctrl: RTL and testbench

Command sequencer placed directly behind the serial receiver. It consumes the receiver's one-cycle byte-available strobe and byte, and assembles fixed 4-byte frames: SYNC, ADDR, DATA, CHK. Each valid frame becomes a single-cycle register-write strobe on a local register bus. Malformed frames and stalled frames are dropped and flagged.

---
 rtl/uart_cmd_ctrl.sv | 119 +++++++++++
 tb/tb_uart_cmd_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer behind the serial receiver: assembles SYNC/ADDR/DATA/CHK
// frames into single-cycle register writes and drops bad or stalled frames.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC    = 8'hAA,
  parameter int         TIMEOUT = 12000,
  parameter int         CW      = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rcv,
  input  logic [7:0] data,
  output logic       wr,
  output logic [7:0] waddr,
  output logic [7:0] wdata,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] nframes
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_SYNC = 2'd1,
    GOT_ADDR = 2'd2,
    GOT_DATA = 2'd3
  } state_t;

  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  function automatic logic [7:0] frame_chk(input logic [7:0] addr_v, input logic [7:0] data_v);
    return addr_v ^ data_v;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [7:0]    addr_r, addr_s;
  logic [7:0]    data_r, data_s;
  logic          wr_s, err_s;

  // Next-state, holding-register and inter-byte timeout logic; a byte always beats the timeout.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    data_s  = data_r;
    wr_s    = 1'b0;
    err_s   = 1'b0;
    if (rcv) begin
      cnt_s = '0;
      case (state_r)
        IDLE: begin
          if (data == SYNC) begin
            state_s = GOT_SYNC;
          end else begin
            state_s = IDLE;
          end
        end
        GOT_SYNC: begin
          addr_s  = data;
          state_s = GOT_ADDR;
        end
        GOT_ADDR: begin
          data_s  = data;
          state_s = GOT_DATA;
        end
        GOT_DATA: begin
          if (data == frame_chk(addr_r, data_r)) begin
            wr_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_s = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end else if (state_r == IDLE) begin
      cnt_s = '0;
    end else if (cnt_r == TERM) begin
      state_s = IDLE;
      err_s   = 1'b1;
      cnt_s   = '0;
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      addr_r    <= 8'h00;
      data_r    <= 8'h00;
      wr        <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      waddr     <= 8'h00;
      wdata     <= 8'h00;
      nframes   <= 8'h00;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      wr        <= wr_s;
      frame_err <= err_s;
      busy      <= (state_s != IDLE);
      if (wr_s) begin
        waddr   <= addr_r;
        wdata   <= data_r;
        nframes <= nframes + 8'd1;
      end else begin
        waddr   <= waddr;
        wdata   <= wdata;
        nframes <= nframes;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized self-checking bench for uart_cmd_ctrl against a byte-stream
// frame model (queue of collected bytes plus time of the last byte).
module tb_uart_cmd_ctrl;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rcv = 1'b0;
  logic [7:0] data = 8'h00;
  logic       wr, frame_err, busy;
  logic [7:0] waddr, wdata, nframes;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_seen = 0;
  int err_seen = 0;

  logic [7:0] m_q[$];
  int         m_last = 0;
  logic       m_wr = 1'b0, m_err = 1'b0;
  logic [7:0] m_waddr = 8'h00, m_wdata = 8'h00, m_nfr = 8'h00;

  uart_cmd_ctrl #(.SYNC(8'hAA), .TIMEOUT(TO), .CW(24)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .data(data),
    .wr(wr), .waddr(waddr), .wdata(wdata), .frame_err(frame_err),
    .busy(busy), .nframes(nframes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Frame model: evaluated with the inputs present at a clock edge.
  task automatic model_edge(input logic r_n, input logic rc, input logic [7:0] d);
    m_wr  = 1'b0;
    m_err = 1'b0;
    if (!r_n) begin
      m_q.delete();
      m_waddr = 8'h00;
      m_wdata = 8'h00;
      m_nfr   = 8'h00;
    end else if (rc) begin
      if (m_q.size() == 0) begin
        if (d == 8'hAA) m_q.push_back(d);
      end else begin
        m_q.push_back(d);
      end
      if (m_q.size() == 4) begin
        if (m_q[3] == (m_q[1] ^ m_q[2])) begin
          m_wr    = 1'b1;
          m_waddr = m_q[1];
          m_wdata = m_q[2];
          m_nfr   = m_nfr + 8'd1;
        end else begin
          m_err = 1'b1;
        end
        m_q.delete();
      end
      m_last = cyc;
    end else if (m_q.size() > 0 && (cyc - m_last) == TO) begin
      m_err = 1'b1;
      m_q.delete();
    end
  endtask

  task automatic step(input logic r_n, input logic rc, input logic [7:0] d);
    rstn = r_n;
    rcv  = rc;
    data = d;
    @(posedge clk);
    cyc++;
    model_edge(r_n, rc, d);
    #1;
    if (wr === 1'b1) wr_seen++;
    if (frame_err === 1'b1) err_seen++;
    check("wr", {31'd0, wr}, {31'd0, m_wr});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_err});
    check("busy", {31'd0, busy}, {31'd0, (m_q.size() > 0)});
    check("waddr", {24'd0, waddr}, {24'd0, m_waddr});
    check("wdata", {24'd0, wdata}, {24'd0, m_wdata});
    check("nframes", {24'd0, nframes}, {24'd0, m_nfr});
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 1; i < gap; i++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    int w0, e0;
    logic [7:0] a, b, saved;

    step(1'b0, 1'b1, 8'hAA);
    step(1'b0, 1'b0, 8'h00);
    check("rst_nframes", {24'd0, nframes}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // good frame, 10 cycles between bytes
    w0 = wr_seen; e0 = err_seen;
    send(8'hAA, 10); send(8'h12, 10); send(8'h34, 10); send(8'h26, 10);
    check("t1_wr_now", {31'd0, wr}, 32'd1);
    idle(3);
    check("t1_wr_count", wr_seen - w0, 32'd1);
    check("t1_err_count", err_seen - e0, 32'd0);
    check("t1_waddr", {24'd0, waddr}, 32'h12);
    check("t1_wdata", {24'd0, wdata}, 32'h34);
    check("t1_nframes", {24'd0, nframes}, 32'd1);

    // bad checksum
    w0 = wr_seen; e0 = err_seen;
    send(8'hAA, 2); send(8'h12, 2); send(8'h34, 2); send(8'h27, 2);
    check("t2_err_now", {31'd0, frame_err}, 32'd1);
    idle(3);
    check("t2_wr_count", wr_seen - w0, 32'd0);
    check("t2_err_count", err_seen - e0, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // leading junk ignored
    w0 = wr_seen; e0 = err_seen;
    send(8'h55, 1); send(8'h00, 1); send(8'hAA, 1);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
    idle(2);
    check("t3_wr_count", wr_seen - w0, 32'd1);
    check("t3_err_count", err_seen - e0, 32'd0);
    check("t3_waddr", {24'd0, waddr}, 32'h01);

    // timeout after ADDR byte
    e0 = err_seen;
    send(8'hAA, 1); send(8'h12, 1);
    idle(TO - 1);
    check("t4_err_early", err_seen - e0, 32'd0);
    idle(1);
    check("t4_err_now", {31'd0, frame_err}, 32'd1);
    idle(4);
    check("t4_busy", {31'd0, busy}, 32'd0);
    send(8'hAA, 1); send(8'h05, 1); send(8'h06, 1); send(8'h03, 1);
    idle(1);
    check("t4_wdata", {24'd0, wdata}, 32'h06);

    // byte on the terminal-count cycle wins
    w0 = wr_seen; e0 = err_seen;
    send(8'hAA, 1); send(8'h10, TO); send(8'h20, TO); send(8'h30, TO);
    idle(2);
    check("t5_err_count", err_seen - e0, 32'd0);
    check("t5_wr_count", wr_seen - w0, 32'd1);
    check("t5_waddr", {24'd0, waddr}, 32'h10);

    // reset mid-frame discards it
    w0 = wr_seen; e0 = err_seen;
    send(8'hAA, 1); send(8'h12, 1);
    step(1'b0, 1'b0, 8'h00);
    send(8'h34, 1); send(8'h26, 1);
    idle(TO + 5);
    check("t6_wr_count", wr_seen - w0, 32'd0);
    check("t6_err_count", err_seen - e0, 32'd0);

    // 256 good frames back to back wrap the counter
    saved = m_nfr;
    for (int f = 0; f < 256; f++) begin
      a = 8'($urandom); b = 8'($urandom);
      send(8'hAA, 1); send(a, 1); send(b, 1); send(a ^ b, 1);
    end
    idle(1);
    check("t6_wrap", {24'd0, nframes}, {24'd0, saved});

    // randomized mix of good, corrupt, stalled and junk traffic
    for (int it = 0; it < 80; it++) begin
      a = 8'($urandom); b = 8'($urandom);
      case ($urandom_range(0, 4))
        0, 1: begin
          send(8'hAA, $urandom_range(1, TO)); send(a, $urandom_range(1, TO));
          send(b, $urandom_range(1, TO)); send(a ^ b, $urandom_range(1, TO));
        end
        2: begin
          send(8'hAA, $urandom_range(1, 5)); send(a, $urandom_range(1, 5));
          send(b, $urandom_range(1, 5)); send(8'($urandom), $urandom_range(1, 5));
        end
        3: begin
          send(8'hAA, 1); send(a, $urandom_range(TO - 1, TO + 2));
          send(b, $urandom_range(1, TO + 2)); send(a ^ b, 1);
        end
        default: begin
          send(8'($urandom_range(0, 1) ? 8'hAA : a), $urandom_range(1, 3));
          if ($urandom_range(0, 7) == 0) step(1'b0, 1'b1, b);
        end
      endcase
    end
    idle(TO + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
